// File: rtl/alu_decode_issue.sv
// Decode/issue stage for RV64IM: decodes one instruction, normalizes func3/func7 for the ALU,
// tracks in-flight destinations in a busy scoreboard and holds a single registered issue slot.
module alu_decode_issue #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned ALU_OP_WIDTH    = 7,
  parameter int unsigned ALU_FUNC3_WIDTH = 3,
  parameter int unsigned ALU_FUNC7_WIDTH = 7,
  parameter int unsigned NUM_REGS        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [DATA_WIDTH-1:0]      in_pc,
  output logic [4:0]                 rs1_addr,
  output logic [4:0]                 rs2_addr,
  input  logic [DATA_WIDTH-1:0]      rs1_data,
  input  logic [DATA_WIDTH-1:0]      rs2_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_OP_WIDTH-1:0]    alu_op,
  output logic [ALU_FUNC3_WIDTH-1:0] func3,
  output logic [ALU_FUNC7_WIDTH-1:0] func7,
  output logic [DATA_WIDTH-1:0]      data1,
  output logic [DATA_WIDTH-1:0]      data2,
  output logic [DATA_WIDTH-1:0]      out_imm,
  output logic [DATA_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_store,
  output logic [4:0]                 out_rd,
  output logic                       out_rd_we,
  output logic                       illegal,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_R32   = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_I32   = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic                       valid;
    logic [ALU_OP_WIDTH-1:0]    op;
    logic [ALU_FUNC3_WIDTH-1:0] f3;
    logic [ALU_FUNC7_WIDTH-1:0] f7;
    logic [DATA_WIDTH-1:0]      d1;
    logic [DATA_WIDTH-1:0]      d2;
    logic [DATA_WIDTH-1:0]      imm;
    logic [DATA_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]      st;
    logic [4:0]                 rd;
    logic                       rd_we;
    logic                       ill;
  } slot_t;

  slot_t                 r_slot;
  logic [NUM_REGS-1:0]   r_busy;

  slot_t                 w_dec;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic [6:0]            w_f7;
  logic [4:0]            w_rd;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic                  w_writes;
  logic                  w_ill;
  logic                  w_hazard;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_imm_i;
  logic [DATA_WIDTH-1:0] w_imm_s;
  logic [DATA_WIDTH-1:0] w_imm_b;
  logic [DATA_WIDTH-1:0] w_imm_u;
  logic [DATA_WIDTH-1:0] w_imm_j;
  logic [DATA_WIDTH-1:0] w_shamt6;
  logic [DATA_WIDTH-1:0] w_shamt5;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_rd     = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign w_imm_i  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u  = {{(DATA_WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j  = {{(DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign w_shamt6 = {{(DATA_WIDTH-6){1'b0}}, in_instr[25:20]};
  assign w_shamt5 = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

  // Decode and operand selection into a candidate slot
  always_comb begin
    w_dec       = '0;
    w_rs1_used  = 1'b0;
    w_rs2_used  = 1'b0;
    w_writes    = 1'b0;
    w_ill       = 1'b0;
    w_dec.valid = 1'b1;
    w_dec.op    = ALU_OP_WIDTH'(w_opcode);
    w_dec.f3    = ALU_FUNC3_WIDTH'(w_f3);
    w_dec.d1    = rs1_data;
    w_dec.d2    = rs2_data;
    w_dec.pc    = in_pc;
    w_dec.st    = rs2_data;
    w_dec.rd    = w_rd;
    case (w_opcode)
      OP_R, OP_R32: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_writes   = 1'b1;
        w_dec.f7   = ALU_FUNC7_WIDTH'(w_f7);
        if (w_f7 != 7'h00 && w_f7 != 7'h20 && w_f7 != 7'h01) w_ill = 1'b1;
        if (w_opcode == OP_R32 && (w_f3 == 3'd2 || w_f3 == 3'd3)) w_ill = 1'b1;
      end
      OP_I, OP_I32: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_dec.d2   = w_imm_i;
        w_dec.imm  = w_imm_i;
        // Shifts: shamt[5] folded out of func7, operand is the raw shift amount
        if (w_f3 == 3'd1 || w_f3 == 3'd5) begin
          w_dec.f7 = ALU_FUNC7_WIDTH'({in_instr[31:26], 1'b0});
          w_dec.d2 = (w_opcode == OP_I) ? w_shamt6 : w_shamt5;
          if (w_opcode == OP_I32 && in_instr[25]) w_ill = 1'b1;
        end
        if (w_opcode == OP_I32 && (w_f3 == 3'd2 || w_f3 == 3'd3)) w_ill = 1'b1;
      end
      OP_LOAD: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_dec.d2   = w_imm_i;
        w_dec.imm  = w_imm_i;
      end
      OP_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec.d2   = w_imm_s;
        w_dec.imm  = w_imm_s;
      end
      OP_BR: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec.imm  = w_imm_b;
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_ill = 1'b1;
      end
      OP_LUI: begin
        w_writes  = 1'b1;
        w_dec.f3  = '0;
        w_dec.d1  = '0;
        w_dec.d2  = w_imm_u;
        w_dec.imm = w_imm_u;
      end
      OP_AUIPC: begin
        w_writes  = 1'b1;
        w_dec.f3  = '0;
        w_dec.d1  = in_pc;
        w_dec.d2  = w_imm_u;
        w_dec.imm = w_imm_u;
      end
      OP_JAL: begin
        w_writes  = 1'b1;
        w_dec.f3  = '0;
        w_dec.d1  = in_pc;
        w_dec.d2  = w_imm_j;
        w_dec.imm = w_imm_j;
      end
      OP_JALR: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_dec.d1   = in_pc;
        w_dec.d2   = w_imm_i;
        w_dec.imm  = w_imm_i;
      end
      default: w_ill = 1'b1;
    endcase
    w_dec.ill   = w_ill;
    w_dec.rd_we = w_writes && !w_ill && (w_rd != 5'd0);
  end

  // Hazard check against registered busy bits only
  assign w_hazard = in_valid && ((w_rs1_used && r_busy[rs1_addr]) ||
                                 (w_rs2_used && r_busy[rs2_addr]) ||
                                 (w_dec.rd_we && r_busy[w_rd]));
  assign in_ready = !reset && !flush && (!r_slot.valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Scoreboard update: clears first, a new issue to the same index wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (flush && r_slot.valid && r_slot.rd_we) w_busy_nxt[r_slot.rd] = 1'b0;
    if (w_accept && w_dec.rd_we) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_slot <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush)          r_slot.valid <= 1'b0;
      else if (w_accept)  r_slot       <= w_dec;
      else if (out_ready) r_slot.valid <= 1'b0;
    end
  end

  assign out_valid = r_slot.valid;
  assign alu_op    = r_slot.op;
  assign func3     = r_slot.f3;
  assign func7     = r_slot.f7;
  assign data1     = r_slot.d1;
  assign data2     = r_slot.d2;
  assign out_imm   = r_slot.imm;
  assign out_pc    = r_slot.pc;
  assign out_store = r_slot.st;
  assign out_rd    = r_slot.rd;
  assign out_rd_we = r_slot.rd_we;
  assign illegal   = r_slot.ill;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Bench for alu_decode_issue: expected issue slots queued at acceptance, checked when consumed.
module tb_alu_decode_issue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, wb_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc, rs1_data, rs2_data;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr;
  logic        in_ready, out_valid, out_rd_we, illegal;
  logic [6:0]  alu_op, func7;
  logic [2:0]  func3;
  logic [63:0] data1, data2, out_imm, out_pc, out_store;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] st;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } slot_t;

  typedef struct {
    slot_t exp;
    slot_t msk;
    string name;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  slot_t w_act;

  assign w_act = {alu_op, func3, func7, data1, data2, out_imm, out_pc, out_store,
                  out_rd, out_rd_we, illegal};

  alu_decode_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .func3(func3), .func7(func7), .data1(data1), .data2(data2),
    .out_imm(out_imm), .out_pc(out_pc), .out_store(out_store),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  // Consumer side: every slot taken by the ALU is compared with the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) q.delete();
    else if (out_valid && flush) begin
      if (q.size() > 0) e = q.pop_front();
    end else if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: actual %h required no issue", w_act);
      end else begin
        e = q.pop_front();
        if (((w_act ^ e.exp) & e.msk) != '0) begin
          errors++;
          $display("FAIL %s: actual %h required %h mask %h", e.name, w_act, e.exp, e.msk);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic slot_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                               input logic [63:0] pc, input logic [63:0] st, input logic [4:0] rd,
                               input logic we, input logic ill);
    mk = {op, f3, f7, d1, d2, imm, pc, st, rd, we, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (2) step();
  endtask

  // Present one instruction until accepted (bounded); queue its expected slot on acceptance
  task automatic issue(input string name, input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2,
                       input slot_t exp, input slot_t msk, input int max_wait);
    int   waited = 0;
    bit   done = 0;
    bit   acc = 0;
    exp_t e;
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = exp; e.msk = msk; e.name = name;
        q.push_back(e);
        acc = 1; done = 1;
      end else if (waited >= max_wait) done = 1;
      else waited++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s_accept: in_ready=0 after %0d cycles, required 1", name, waited + 1);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    idle_inputs();
    in_valid = 1'b1; in_instr = 32'h00500093;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: actual %b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: actual %b required 0", out_valid); end
    checks++;
    if (w_act !== '0) begin errors++; $display("FAIL reset_outputs: actual %h required 0", w_act); end
    step();
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_raw();
    slot_t m;
    do_reset();
    m = '1; m.st = '0;
    issue("raw_addi", 32'h00500093, 64'h1000, 64'h0, 64'hABCD,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd5, 64'd5, 64'h1000, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 64'h1004; rs1_data = 64'h11; rs2_data = 64'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: cycle %0d in_ready %b required 0", i, in_ready); end
      step();
    end
    @(negedge clk);
    checks++;
    if ({rs1_addr, rs2_addr} !== {5'd1, 5'd1}) begin
      errors++; $display("FAIL raw_addr: actual rs1=%0d rs2=%0d required 1 1", rs1_addr, rs2_addr);
    end
    step();
    wb_valid = 1'b1; wb_rd = 5'd1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_no_bypass: in_ready %b required 0", in_ready); end
    step();
    wb_valid = 1'b0;
    m = '1; m.imm = '0; m.st = '0;
    issue("raw_add", 32'h00108133, 64'h1004, 64'h11, 64'h22,
          mk(7'h33, 3'd0, 7'h00, 64'h11, 64'h22, 64'h0, 64'h1004, 64'h0, 5'd2, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_shift();
    slot_t m;
    do_reset();
    m = '1; m.imm = '0; m.st = '0;
    issue("srai", 32'h42115193, 64'h2000, 64'hF0, 64'h0,
          mk(7'h13, 3'd5, 7'h20, 64'hF0, 64'd33, 64'h0, 64'h2000, 64'h0, 5'd3, 1'b1, 1'b0), m, 0);
    m = '0; m.op = '1; m.pc = '1; m.we = 1'b1; m.ill = 1'b1;
    issue("slliw_shamt5", 32'h0201121B, 64'h2004, 64'h5, 64'h0,
          mk(7'h1B, 3'd0, 7'h00, 64'h0, 64'h0, 64'h0, 64'h2004, 64'h0, 5'd0, 1'b0, 1'b1), m, 0);
    m = '1; m.st = '0;
    issue("illegal_no_busy", 32'h00120293, 64'h2008, 64'h7, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h7, 64'd1, 64'd1, 64'h2008, 64'h0, 5'd5, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_imm();
    slot_t m;
    do_reset();
    m = '0; m.op = '1; m.f7 = '1; m.d2 = '1; m.pc = '1; m.rd = '1; m.we = 1'b1; m.ill = 1'b1;
    issue("lui", 32'h800002B7, 64'h3000, 64'h99, 64'h77,
          mk(7'h37, 3'd0, 7'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h3000, 64'h0, 5'd5, 1'b1, 1'b0), m, 0);
    m = '1; m.st = '0; m.rd = '0;
    issue("beq", 32'h00208463, 64'h3004, 64'h123, 64'h456,
          mk(7'h63, 3'd0, 7'h00, 64'h123, 64'h456, 64'd8, 64'h3004, 64'h0, 5'd0, 1'b0, 1'b0), m, 0);
    m = '0; m.op = '1; m.pc = '1; m.we = 1'b1; m.ill = 1'b1;
    issue("branch_f3_2", 32'h0020A463, 64'h3008, 64'h1, 64'h2,
          mk(7'h63, 3'd0, 7'h00, 64'h0, 64'h0, 64'h0, 64'h3008, 64'h0, 5'd0, 1'b0, 1'b1), m, 0);
    m = '1; m.d2 = '0; m.rd = '0;
    issue("sd", 32'h0020B423, 64'h300C, 64'h100, 64'hDEAD,
          mk(7'h23, 3'd3, 7'h00, 64'h100, 64'h0, 64'd8, 64'h300C, 64'hDEAD, 5'd0, 1'b0, 1'b0), m, 0);
    m = '1; m.st = '0; m.f3 = '0; m.imm = '0;
    issue("auipc", 32'h00001317, 64'h3010, 64'h5, 64'h6,
          mk(7'h17, 3'd0, 7'h00, 64'h3010, 64'h1000, 64'h0, 64'h3010, 64'h0, 5'd6, 1'b1, 1'b0), m, 0);
    m = '1; m.st = '0; m.f3 = '0; m.d2 = '0;
    issue("jal", 32'h010000EF, 64'h3014, 64'h5, 64'h6,
          mk(7'h6F, 3'd0, 7'h00, 64'h3014, 64'h0, 64'd16, 64'h3014, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_rtype();
    slot_t m;
    do_reset();
    m = '1; m.imm = '0; m.st = '0;
    issue("mul", 32'h02108133, 64'h3100, 64'h3, 64'h4,
          mk(7'h33, 3'd0, 7'h01, 64'h3, 64'h4, 64'h0, 64'h3100, 64'h0, 5'd2, 1'b1, 1'b0), m, 0);
    m = '0; m.op = '1; m.pc = '1; m.we = 1'b1; m.ill = 1'b1;
    issue("r_bad_func7", 32'h04108133, 64'h3104, 64'h3, 64'h4,
          mk(7'h33, 3'd0, 7'h00, 64'h0, 64'h0, 64'h0, 64'h3104, 64'h0, 5'd0, 1'b0, 1'b1), m, 0);
    drain();
  endtask

  task automatic test_backpressure();
    slot_t m;
    do_reset();
    out_ready = 1'b0;
    m = '1; m.st = '0;
    issue("bp_addi", 32'h00500093, 64'h4000, 64'h0, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd5, 64'd5, 64'h4000, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    in_valid = 1'b1; in_instr = 32'h00300393; in_pc = 64'h4004; rs1_data = '0; rs2_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, alu_op, data2, out_pc, out_rd} !==
          {1'b0, 1'b1, 7'h13, 64'd5, 64'h4000, 5'd1}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d in_ready=%b out_valid=%b op=%h data2=%h pc=%h rd=%0d required 0 1 13 5 4000 1",
                 i, in_ready, out_valid, alu_op, data2, out_pc, out_rd);
      end
      step();
    end
    out_ready = 1'b1;
    issue("bp_back_to_back", 32'h00300393, 64'h4004, 64'h0, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd3, 64'd3, 64'h4004, 64'h0, 5'd7, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_flush();
    slot_t m;
    do_reset();
    out_ready = 1'b0;
    m = '1;
    issue("fl_addi", 32'h00500093, 64'h5000, 64'h0, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd5, 64'd5, 64'h5000, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300393; in_pc = 64'h5004;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_no_accept: in_ready %b required 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: out_valid %b required 0", out_valid); end
    step();
    out_ready = 1'b1;
    m = '1; m.imm = '0; m.st = '0;
    issue("flush_busy_cleared", 32'h00108133, 64'h5008, 64'h31, 64'h32,
          mk(7'h33, 3'd0, 7'h00, 64'h31, 64'h32, 64'h0, 64'h5008, 64'h0, 5'd2, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_set_wins();
    slot_t m;
    do_reset();
    m = '1; m.st = '0;
    wb_valid = 1'b1; wb_rd = 5'd1;
    issue("sw_addi", 32'h00500093, 64'h6000, 64'h0, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd5, 64'd5, 64'h6000, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    wb_valid = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 64'h6004;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL set_wins_stall: in_ready %b required 0", in_ready); end
    step();
    wb_valid = 1'b1; wb_rd = 5'd1;
    step();
    wb_valid = 1'b0;
    m = '1; m.imm = '0; m.st = '0;
    issue("sw_add", 32'h00108133, 64'h6004, 64'h41, 64'h42,
          mk(7'h33, 3'd0, 7'h00, 64'h41, 64'h42, 64'h0, 64'h6004, 64'h0, 5'd2, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  task automatic test_reset_mid_stall();
    slot_t m;
    do_reset();
    m = '1; m.st = '0;
    issue("rs_addi", 32'h00500093, 64'h7000, 64'h0, 64'h0,
          mk(7'h13, 3'd0, 7'h00, 64'h0, 64'd5, 64'd5, 64'h7000, 64'h0, 5'd1, 1'b1, 1'b0), m, 0);
    in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 64'h7004;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_stall: in_ready %b required 0", in_ready); end
    step();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, w_act} !== '0) begin
      errors++; $display("FAIL rs_during_reset: in_ready=%b out_valid=%b outputs=%h required all 0", in_ready, out_valid, w_act);
    end
    step();
    reset = 1'b0;
    m = '1; m.imm = '0; m.st = '0;
    issue("rs_add_after_reset", 32'h00108133, 64'h7004, 64'h51, 64'h52,
          mk(7'h33, 3'd0, 7'h00, 64'h51, 64'h52, 64'h0, 64'h7004, 64'h0, 5'd2, 1'b1, 1'b0), m, 0);
    drain();
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_raw();
    test_shift();
    test_imm();
    test_rtype();
    test_backpressure();
    test_flush();
    test_set_wins();
    test_reset_mid_stall();
    drain();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected slots never issued, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
